// File: rtl/bool_sweep_checker_if.sv
// bool_sweep_checker_if: bundle between the sweep checker and the functions under test.
// Ports: start, f_d/f_b/f_s into the checker; vec_out, strobe, status and result signals out of it.
interface bool_sweep_checker_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 4
);
  logic             start;
  logic [N_IN-1:0]  vec_out;
  logic             f_d;
  logic             f_b;
  logic             f_s;
  logic             sample_valid;
  logic             sample_match;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_count;
  logic [N_IN-1:0]  first_fail_vec;
  logic             first_fail_valid;

  modport master (
    input  start,
    input  f_d,
    input  f_b,
    input  f_s,
    output vec_out,
    output sample_valid,
    output sample_match,
    output busy,
    output done,
    output pass,
    output mismatch_count,
    output first_fail_vec,
    output first_fail_valid
  );

  modport slave (
    output start,
    output f_d,
    output f_b,
    output f_s,
    input  vec_out,
    input  sample_valid,
    input  sample_match,
    input  busy,
    input  done,
    input  pass,
    input  mismatch_count,
    input  first_fail_vec,
    input  first_fail_valid
  );
endinterface

// File: rtl/bool_sweep_checker.sv
// bool_sweep_checker: exhaustive clocked sweep that compares three Boolean implementations.
// Ports: clk, rst (sync, active high); bus (master): start, f_* in; vec_out, strobes, results out.
module bool_sweep_checker #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bool_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [N_IN-1:0]  VEC_LAST    = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state_q;
  state_e           state_d;
  logic [N_IN-1:0]  vec_q;
  logic [N_IN-1:0]  vec_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic [CNT_W-1:0] mis_q;
  logic [CNT_W-1:0] mis_d;
  logic [N_IN-1:0]  ffv_q;
  logic [N_IN-1:0]  ffv_d;
  logic             ffval_q;
  logic             ffval_d;

  logic start_ok;
  logic mismatch;
  logic last_vec;
  logic settled;

  // start only counts when no sweep is in flight
  assign start_ok = bus.start &&
                    (state_q == S_IDLE || state_q == S_DONE);
  assign mismatch = !((bus.f_d == bus.f_b) &&
                      (bus.f_b == bus.f_s));
  assign last_vec = (vec_q == VEC_LAST);
  assign settled  = (cnt_q == SETTLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_WAIT;
      S_WAIT:  if (settled)  state_d = S_CHECK;
      S_CHECK: state_d = last_vec ? S_DONE : S_WAIT;
      S_DONE:  if (start_ok) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.sample_valid     = 1'b0;
    bus.sample_match     = 1'b0;
    bus.busy             = 1'b0;
    bus.done             = 1'b0;
    bus.pass             = 1'b0;
    bus.vec_out          = vec_q;
    bus.mismatch_count   = mis_q;
    bus.first_fail_vec   = ffv_q;
    bus.first_fail_valid = ffval_q;
    unique case (state_q)
      S_IDLE: ;
      S_WAIT: bus.busy = 1'b1;
      S_CHECK: begin
        bus.busy         = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_match = !mismatch;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.pass = (mis_q == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          vec_d   = '0;
          cnt_d   = '0;
          mis_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
        end
      end
      S_WAIT: cnt_d = cnt_q + 4'd1;
      S_CHECK: begin
        if (mismatch) begin
          if (mis_q != CNT_MAX) mis_d = mis_q + 1'b1;
          if (!ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
        end
        // final vector is held through DONE
        if (!last_vec) begin
          vec_d = vec_q + 1'b1;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
    end
  end

endmodule
